bus_drive_arbiter: RTL and testbench

Round-robin arbiter that shares the 32-bit tri-state data bus between NREQ drivers. It generates the one-hot drive enables (the per-driver dcontrol signals) that gate each driver's data onto the bus. It inserts a mandatory turnaround gap between owners, so two drivers never enable on the same cycle. It sits beside the bus wiring and is the only source of drive enables.

---
 rtl/bus_drive_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_bus_drive_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_drive_arbiter.sv
// bus_drive_arbiter
//
// Round-robin owner selection for the shared 32-bit tri-state data bus. Produces the
// registered one-hot drive enables (dcontrol) that gate each driver onto the bus, and
// forces an all-low turnaround gap between successive owners so two drivers can never
// be enabled on the same cycle.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset; drops all enables immediately
//   req      - per-driver bus request, held high while the driver wants the bus
//   dcontrol - registered one-hot drive enable, bit i lets driver i drive the bus
//   gnt_id   - index of the current owner, meaningful only while bus_busy is high
//   bus_busy - registered, high whenever any dcontrol bit is high
//   preempt  - one-cycle pulse when an owner is removed by the hold limit
//
// Build option:
//   BUS_ARB_HOLD_LIMIT_EN - when defined, an owner that has held the bus for MAX_HOLD
//   cycles while another driver is waiting is forcibly released. When undefined, an
//   owner keeps the bus until it drops req and preempt is tied low.

module bus_drive_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] dcontrol,
  output logic [2:0]      gnt_id,
  output logic            bus_busy,
  output logic            preempt
);

  typedef enum logic [1:0] {StIdle, StOwn, StTurn} state_e;

  state_e          state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      owner_q, owner_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [2:0]      turn_cnt_q, turn_cnt_d;
  logic [NREQ-1:0] dcontrol_q, dcontrol_d;
  logic            busy_q, busy_d;

  // Round-robin pick: rotate req so rr_ptr lands on bit 0, take the lowest set bit,
  // then map that offset back to an absolute driver index.
  logic [NREQ-1:0] req_rot;
  logic [2:0]      first_off;
  logic [3:0]      win_sum;
  logic [2:0]      winner;

  assign req_rot = NREQ'({req, req} >> rr_ptr_q);

  always_comb begin
    first_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) first_off = 3'(i);
    end
  end

  always_comb begin
    win_sum = {1'b0, rr_ptr_q} + {1'b0, first_off};
    if (win_sum >= 4'(NREQ)) win_sum = win_sum - 4'(NREQ);
  end

  assign winner = 3'(win_sum);

  // In StOwn dcontrol_q is exactly the owner's bit, so masking req with it avoids a
  // variable-index select.
  logic owner_req, others_req, hold_hit, release_ev, preempt_ev;

  assign owner_req  = |(req & dcontrol_q);
  assign others_req = |(req & ~dcontrol_q);

`ifdef BUS_ARB_HOLD_LIMIT_EN
  assign hold_hit = (hold_cnt_q == 8'(MAX_HOLD - 1)) && others_req;
`else
  assign hold_hit = 1'b0;
`endif

  // An owner dropping req on the same edge the limit fires is an ordinary release,
  // so preempt is only raised when the owner still wanted the bus.
  assign release_ev = (state_q == StOwn) && (!owner_req || hold_hit);
  assign preempt_ev = (state_q == StOwn) && owner_req && hold_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      dcontrol_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      dcontrol_q <= dcontrol_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d    = StOwn;
          owner_d    = winner;
          hold_cnt_d = '0;
        end
      end
      StOwn: begin
        if (hold_cnt_q != 8'hff) hold_cnt_d = hold_cnt_q + 8'd1;
        if (release_ev) begin
          rr_ptr_d = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;
          if (TURN_CYC == 0) begin
            state_d = StIdle;
          end else begin
            state_d    = StTurn;
            turn_cnt_d = 3'(TURN_CYC - 1);
          end
        end
      end
      StTurn: begin
        if (turn_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          turn_cnt_d = turn_cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered output next values
  always_comb begin
    dcontrol_d = dcontrol_q;
    busy_d     = busy_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          dcontrol_d = {{(NREQ - 1){1'b0}}, 1'b1} << winner;
          busy_d     = 1'b1;
        end
      end
      StOwn: begin
        if (release_ev) begin
          dcontrol_d = '0;
          busy_d     = 1'b0;
        end
      end
      default: begin
        dcontrol_d = '0;
        busy_d     = 1'b0;
      end
    endcase
  end

`ifdef BUS_ARB_HOLD_LIMIT_EN
  logic preempt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt_ev;
    end
  end

  assign preempt = preempt_q;
`else
  logic unused_hold_cfg;

  assign unused_hold_cfg = ^{preempt_ev, others_req, 8'(MAX_HOLD)};
  assign preempt         = 1'b0;
`endif

  assign dcontrol = dcontrol_q;
  assign gnt_id   = owner_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Self-checking bench for bus_drive_arbiter. Three instances share one req vector:
// index 0 uses TURN_CYC=1, index 1 TURN_CYC=0, index 2 TURN_CYC=3 (all MAX_HOLD=4).
// A transaction-level model (owner / gap countdown / pointer) predicts every cycle.

module tb_bus_drive_arbiter;

  localparam int N    = 4;
  localparam int NI   = 3;
  localparam int MAXH = 4;
`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '1;
  logic [N-1:0] dc   [NI];
  logic [2:0]   gid  [NI];
  logic         busy [NI];
  logic         pre  [NI];

  always #5 clk = ~clk;

  bus_drive_arbiter #(.NREQ(N), .TURN_CYC(1), .MAX_HOLD(MAXH)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .dcontrol(dc[0]), .gnt_id(gid[0]),
    .bus_busy(busy[0]), .preempt(pre[0])
  );

  bus_drive_arbiter #(.NREQ(N), .TURN_CYC(0), .MAX_HOLD(MAXH)) u_dut_t0 (
    .clk(clk), .rst_n(rst_n), .req(req), .dcontrol(dc[1]), .gnt_id(gid[1]),
    .bus_busy(busy[1]), .preempt(pre[1])
  );

  bus_drive_arbiter #(.NREQ(N), .TURN_CYC(3), .MAX_HOLD(MAXH)) u_dut_t3 (
    .clk(clk), .rst_n(rst_n), .req(req), .dcontrol(dc[2]), .gnt_id(gid[2]),
    .bus_busy(busy[2]), .preempt(pre[2])
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = none), remaining turnaround cycles, pointer,
  // cycles owned so far, preempt flag for the cycle just entered.
  int   m_owner [NI];
  int   m_gap   [NI];
  int   m_rr    [NI];
  int   m_held  [NI];
  bit   m_pre   [NI];
  int   waits   [NI][N];
  int   max_wait[NI];
  logic prev_busy[NI];

  function automatic int turn_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_owner[k]   = -1;
      m_gap[k]     = 0;
      m_rr[k]      = 0;
      m_held[k]    = 0;
      m_pre[k]     = 1'b0;
      prev_busy[k] = 1'b0;
      for (int i = 0; i < N; i++) waits[k][i] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] r);
    for (int k = 0; k < NI; k++) begin
      m_pre[k] = 1'b0;
      if (m_owner[k] >= 0) begin
        int           o;
        logic [N-1:0] others;
        o         = m_owner[k];
        others    = r;
        others[o] = 1'b0;
        if (!r[o] || (LIMIT && m_held[k] == MAXH && others != '0)) begin
          m_pre[k]   = r[o];
          m_rr[k]    = (o + 1) % N;
          m_owner[k] = -1;
          m_gap[k]   = turn_of(k);
        end else if (m_held[k] < 256) begin
          m_held[k]++;
        end
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
      end else if (r != '0) begin
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_rr[k] + i) % N;
          if (r[c]) begin
            m_owner[k] = c;
            m_held[k]  = 1;
            break;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input logic [N-1:0] r, input bit stepped);
    for (int k = 0; k < NI; k++) begin
      int exp_dc;
      exp_dc = (m_owner[k] >= 0) ? (1 << m_owner[k]) : 0;
      check_eq($sformatf("dcontrol[%0d]", k), dc[k], exp_dc);
      check_eq($sformatf("bus_busy[%0d]", k), busy[k], m_owner[k] >= 0);
      check_eq($sformatf("preempt[%0d]", k), pre[k], m_pre[k]);
      if (m_owner[k] >= 0) check_eq($sformatf("gnt_id[%0d]", k), gid[k], m_owner[k]);
      check_eq($sformatf("onehot0[%0d]", k), $onehot0(dc[k]), 1);
      check_eq($sformatf("busy_or[%0d]", k), busy[k], |dc[k]);
      // Count grants to other drivers while a driver keeps requesting.
      if (stepped) begin
        for (int i = 0; i < N; i++) if (!r[i]) waits[k][i] = 0;
        if (busy[k] && !prev_busy[k]) begin
          for (int i = 0; i < N; i++) begin
            if (i == int'(gid[k])) begin
              waits[k][i] = 0;
            end else if (r[i]) begin
              waits[k][i]++;
              if (waits[k][i] > max_wait[k]) max_wait[k] = waits[k][i];
            end
          end
        end
      end
      prev_busy[k] = busy[k];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(req);
    #1;
    compare_all(req, rst_n);
  endtask

  // Asserted mid-cycle: enables must fall without a clock edge.
  task automatic apply_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_dcontrol", dc[0], 0);
    check_eq("async_rst_busy", busy[0], 0);
    compare_all(req, 1'b0);
    tick();
    #3 rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int id);
    id = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (busy[0]) begin
        id = gid[0];
        break;
      end
    end
  endtask

  initial begin
    int grants[$];
    int zeros, own, pre_cnt, nxt, id;
    bit seen, released;
    logic prev_b;

    for (int k = 0; k < NI; k++) max_wait[k] = 0;
    model_reset();

    // Reset held with all requests high
    tick();
    tick();
    check_eq("rst_dcontrol", dc[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_preempt", pre[0], 0);
    check_eq("rst_gnt_id", gid[0], 0);
    #3 rst_n = 1'b1;

    // Single requester, release, turnaround timing
    req = 4'b0100;
    tick();
    check_eq("single_dcontrol", dc[0], 4'b0100);
    check_eq("single_gnt_id", gid[0], 2);
    tick();
    tick();
    tick();
    req = 4'b0000;
    tick();
    check_eq("release_dcontrol", dc[0], 0);
    check_eq("release_busy", busy[0], 0);
    req = 4'b0100;
    tick();
    check_eq("turn_dcontrol", dc[0], 0);
    tick();
    check_eq("regrant_dcontrol", dc[0], 4'b0100);
    tick();
    apply_reset();

    // Round robin with every owner dropping req after three cycles
    req    = 4'hF;
    zeros  = 0;
    seen   = 1'b0;
    prev_b = 1'b0;
    for (int c = 0; c < 80 && grants.size() < 5; c++) begin
      tick();
      if (busy[0] && !prev_b) begin
        if (seen) check_eq("rr_gap_ge2", zeros >= 2, 1);
        grants.push_back(int'(gid[0]));
        seen  = 1'b1;
        zeros = 0;
      end else if (!busy[0]) begin
        zeros++;
      end
      prev_b = busy[0];
      req    = 4'hF;
      if (m_owner[0] >= 0 && m_held[0] >= 3) req[m_owner[0]] = 1'b0;
    end
    check_eq("rr_count", grants.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rr_order%0d", i), (i < grants.size()) ? grants[i] : -1, i % 4);
    end
    apply_reset();

    // Wrap from pointer 3, then skip a non-requester
    req = 4'b0100;
    tick();
    check_eq("wrap_setup_gnt", gid[0], 2);
    req = 4'b0001;
    tick();
    req = 4'b0101;
    wait_grant(id);
    check_eq("wrap_grant", id, 0);
    req = 4'b0100;
    tick();
    wait_grant(id);
    check_eq("skip_grant", id, 2);
    apply_reset();

    // Hold limit: driver 1 holds, driver 3 joins one cycle later
    req = 4'b0010;
    tick();
    req      = 4'b1010;
    own      = 1;
    pre_cnt  = 0;
    nxt      = -1;
    released = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (!released && dc[0] == 4'b0010) own++;
      else released = 1'b1;
      if (pre[0]) pre_cnt++;
      if (released && busy[0] && nxt < 0) nxt = gid[0];
    end
    check_eq("hold_owner_cycles", own, LIMIT ? 4 : 9);
    check_eq("hold_preempt_pulses", pre_cnt, LIMIT ? 1 : 0);
    check_eq("hold_next_owner", nxt, LIMIT ? 3 : -1);
    apply_reset();

    // Random sticky requests across all three turnaround settings
    req = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("fair_wait[%0d]", k), max_wait[k] <= N - 1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
